// File: rtl/parking_occupancy_counter_if.sv
// Sensor inputs and occupancy outputs of parking_occupancy_counter.
// The slave modport is the counter; the master modport is whoever drives the sensors.
interface parking_occupancy_counter_if;
  logic        sensor_a;
  logic        sensor_b;
  logic [15:0] count_bcd;
  logic        car_enter;
  logic        car_exit;
  logic        seq_error;
  logic        lot_full;
  logic        lot_empty;

  modport master (
    output sensor_a, sensor_b,
    input  count_bcd, car_enter, car_exit, seq_error, lot_full, lot_empty
  );

  modport slave (
    input  sensor_a, sensor_b,
    output count_bcd, car_enter, car_exit, seq_error, lot_full, lot_empty
  );
endinterface

// File: rtl/parking_occupancy_counter.sv
// Gate sensor sequencer plus saturating 4-digit BCD occupancy counter.
// Optional macro SENSOR_SYNC_EN inserts a two-flop synchronizer on each sensor.
module parking_occupancy_counter #(
  parameter logic [15:0] MAX_COUNT = 16'h9999
) (
  input  logic                        clk,
  input  logic                        rst,
  parking_occupancy_counter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_EN1, S_EN2, S_EN3, S_EX1, S_EX2, S_EX3, S_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  w_ab;
  logic        w_enter_next;
  logic        w_exit_next;
  logic        w_err_next;
  logic        r_car_enter;
  logic        r_car_exit;
  logic        r_seq_error;
  logic [15:0] r_count_bcd;
  logic [15:0] w_inc_bcd;
  logic [15:0] w_dec_bcd;
  logic [3:0]  w_inc_carry;
  logic [3:0]  w_dec_borrow;
  logic        w_full;
  logic        w_empty;

`ifdef SENSOR_SYNC_EN
  logic [1:0] r_sync_a;
  logic [1:0] r_sync_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_a <= 2'b00;
      r_sync_b <= 2'b00;
    end else begin
      r_sync_a <= {r_sync_a[0], bus.sensor_a};
      r_sync_b <= {r_sync_b[0], bus.sensor_b};
    end
  end

  assign w_ab = {r_sync_a[1], r_sync_b[1]};
`else
  assign w_ab = {bus.sensor_a, bus.sensor_b};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_car_enter <= 1'b0;
      r_car_exit  <= 1'b0;
      r_seq_error <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_car_enter <= w_enter_next;
      r_car_exit  <= w_exit_next;
      r_seq_error <= w_err_next;
    end
  end

  // Entry walks 00-10-11-01-00, exit walks the mirror; a two-step jump is illegal.
  always_comb begin
    w_state_next = r_state;
    w_enter_next = 1'b0;
    w_exit_next  = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      S_IDLE: case (w_ab)
        2'b10:   w_state_next = S_EN1;
        2'b01:   w_state_next = S_EX1;
        2'b11:   begin w_state_next = S_WAIT; w_err_next = 1'b1; end
        default: w_state_next = S_IDLE;
      endcase
      S_EN1: case (w_ab)
        2'b11:   w_state_next = S_EN2;
        2'b00:   w_state_next = S_IDLE;
        2'b01:   begin w_state_next = S_WAIT; w_err_next = 1'b1; end
        default: w_state_next = S_EN1;
      endcase
      S_EN2: case (w_ab)
        2'b01:   w_state_next = S_EN3;
        2'b10:   w_state_next = S_EN1;
        2'b00:   begin w_state_next = S_WAIT; w_err_next = 1'b1; end
        default: w_state_next = S_EN2;
      endcase
      S_EN3: case (w_ab)
        2'b11:   w_state_next = S_EN2;
        2'b00:   begin w_state_next = S_IDLE; w_enter_next = 1'b1; end
        2'b10:   begin w_state_next = S_WAIT; w_err_next = 1'b1; end
        default: w_state_next = S_EN3;
      endcase
      S_EX1: case (w_ab)
        2'b11:   w_state_next = S_EX2;
        2'b00:   w_state_next = S_IDLE;
        2'b10:   begin w_state_next = S_WAIT; w_err_next = 1'b1; end
        default: w_state_next = S_EX1;
      endcase
      S_EX2: case (w_ab)
        2'b10:   w_state_next = S_EX3;
        2'b01:   w_state_next = S_EX1;
        2'b00:   begin w_state_next = S_WAIT; w_err_next = 1'b1; end
        default: w_state_next = S_EX2;
      endcase
      S_EX3: case (w_ab)
        2'b11:   w_state_next = S_EX2;
        2'b00:   begin w_state_next = S_IDLE; w_exit_next = 1'b1; end
        2'b01:   begin w_state_next = S_WAIT; w_err_next = 1'b1; end
        default: w_state_next = S_EX3;
      endcase
      S_WAIT: begin
        if (w_ab == 2'b00) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_inc_carry[0]  = 1'b1;
  assign w_dec_borrow[0] = 1'b1;

  // Per-digit BCD increment/decrement with ripple carry and borrow.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] w_digit;
      assign w_digit = r_count_bcd[4*gi +: 4];
      assign w_inc_bcd[4*gi +: 4] = !w_inc_carry[gi] ? w_digit :
                                    (w_digit == 4'd9) ? 4'd0 : w_digit + 4'd1;
      assign w_dec_bcd[4*gi +: 4] = !w_dec_borrow[gi] ? w_digit :
                                    (w_digit == 4'd0) ? 4'd9 : w_digit - 4'd1;
      if (gi < 3) begin : g_chain
        assign w_inc_carry[gi+1]  = w_inc_carry[gi]  & (w_digit == 4'd9);
        assign w_dec_borrow[gi+1] = w_dec_borrow[gi] & (w_digit == 4'd0);
      end
    end
  endgenerate

  assign w_full  = (r_count_bcd == MAX_COUNT);
  assign w_empty = (r_count_bcd == 16'h0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count_bcd <= 16'h0000;
    end else if (w_enter_next && !w_full) begin
      r_count_bcd <= w_inc_bcd;
    end else if (w_exit_next && !w_empty) begin
      r_count_bcd <= w_dec_bcd;
    end
  end

  assign bus.count_bcd = r_count_bcd;
  assign bus.car_enter = r_car_enter;
  assign bus.car_exit  = r_car_exit;
  assign bus.seq_error = r_seq_error;
  assign bus.lot_full  = w_full;
  assign bus.lot_empty = w_empty;

endmodule

// File: doc/parking_occupancy_counter.md
# parking_occupancy_counter

Sequential front end of the parking-lot occupancy counter. It watches two photo-sensor inputs across the lot gate, recognises complete car-entry and car-exit sequences, and keeps the occupancy as a 4-digit packed BCD count. The BCD count drives the downstream decimal/display path directly; no further binary conversion is needed.

## Interface

Parameters:
- `MAX_COUNT`, default 16'h9999: packed-BCD saturation ceiling; each nibble must be 0–9.

Ports:
- `clk` input 1: system clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `sensor_a` input 1: outer beam, 1 = blocked.
- `sensor_b` input 1: inner beam, 1 = blocked.
- `count_bcd` output 16: occupancy, packed BCD; [3:0] is the units digit.
- `car_enter` output 1: one-cycle pulse on each completed entry.
- `car_exit` output 1: one-cycle pulse on each completed exit.
- `seq_error` output 1: one-cycle pulse when an illegal sensor transition is detected.
- `lot_full` output 1: high while `count_bcd == MAX_COUNT`.
- `lot_empty` output 1: high while `count_bcd == 0`.

Clocking and reset: one clock; reset is asynchronous and active-high.

## Operation

- Define `ab` = {a, b} as seen by the FSM: synchronized or raw, per Configuration.
- FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT.
- Entry sequence is 00→10→11→01→00. Exit sequence is 00→01→11→10→00.
- IDLE transitions:
  - 10 → EN1.
  - 01 → EX1.
  - 11 → WAIT, with `seq_error`.
  - 00 → stay.
- EN1 transitions:
  - 10 → stay.
  - 11 → EN2.
  - 00 → IDLE, no count (car backed out).
  - 01 → WAIT, with `seq_error`.
- EN2 transitions:
  - 11 → stay.
  - 01 → EN3.
  - 10 → EN1 (backtrack).
  - 00 → WAIT, with `seq_error`.
- EN3 transitions:
  - 01 → stay.
  - 11 → EN2 (backtrack).
  - 00 → IDLE and `car_enter`.
  - 10 → WAIT, with `seq_error`.
- EX1, EX2 and EX3 mirror EN1–EN3 with a and b swapped. EX3 with 00 → IDLE and `car_exit`.
- WAIT: stays until `ab == 00`, then → IDLE. No error pulse is issued while in WAIT.
- Counter on `car_enter`:
  - BCD increment with per-digit carry (9 → 0, carry into the next digit).
  - If `count_bcd == MAX_COUNT`, the count holds; `car_enter` still pulses.
- Counter on `car_exit`:
  - BCD decrement with per-digit borrow (0 → 9, borrow from the next digit).
  - If `count_bcd == 0`, the count holds; `car_exit` still pulses.
- `car_enter` and `car_exit` are mutually exclusive by construction and are never high together.
- `lot_full` and `lot_empty` are decoded from the `count_bcd` register. No extra latency is added.

## Timing

Reset values:
- State = IDLE.
- `count_bcd` = 16'h0000.
- `car_enter`, `car_exit`, `seq_error` = 0.
- `lot_empty` = 1.
- `lot_full` = 0, unless `MAX_COUNT == 0`.

Latency:
- `car_enter`/`car_exit` and the updated `count_bcd` appear together on the clock edge that samples the terminating `ab == 00`.
- That is 1 cycle after the FSM sees 00, or 3 cycles after the raw pins change when the synchronizer is enabled.

Other timing rules:
- Pulses are exactly one cycle wide. A sensor held at 00 produces no repeated pulses.
- Reset asserted mid-sequence aborts the sequence: no pulse, count cleared. After release, the FSM starts from IDLE and needs a full new sequence.
- Back-to-back cars are supported: a new entry may begin on the cycle right after a pulse, because IDLE with 10 → EN1.

## Configuration

- `SENSOR_SYNC_EN` defined:
  - Each of `sensor_a` and `sensor_b` passes through its own two-flop synchronizer before the FSM.
  - Synchronizer flops reset to 0.
  - Adds 2 cycles of latency.
- `SENSOR_SYNC_EN` undefined: the FSM samples the raw inputs directly, and the inputs must already be synchronous to `clk`.

## Test plan

- Reset, then a full entry 00→10→11→01→00 with each step held 3 cycles → one `car_enter` pulse, `count_bcd` = 0001, `lot_empty` falls the same cycle.
- Preload to 0009 by 9 entries, then one more entry → 0010. Preload to 0099, then one entry → 0100. Preload to 0100, then one exit → 0099.
- `MAX_COUNT` = 16'h0003 and 4 entries → count stays 0003, `lot_full` = 1, fourth `car_enter` still pulses. From 0000, one exit → stays 0000 with a `car_exit` pulse.
- Backtrack 00→10→11→10→00 → no pulse, count unchanged, state IDLE. Jittery sequence 10→11→01→11→01→00 → exactly one `car_enter`.
- Illegal transition 00→10→01 → one `seq_error` pulse. Then 01→11→00 → no further pulses, return to IDLE.
- Assert `rst` while in EN3 → `count_bcd` = 0000 immediately (async), no `car_enter`. With `SENSOR_SYNC_EN`, repeat the first scenario and check the pulse arrives 2 cycles later.
